// File: rtl/midas_pixel_fetch.sv
// midas_pixel_fetch: nearest-neighbour upscaler that turns panel timing into
// frame-buffer reads and RGB444 -> RGB565 panel pixels.
// Ports:
//   clk_pix, rstn                   pixel clock, async-assert active-low reset
//   frame_start, de_in, hsync_in, vsync_in   timing generator inputs
//   fb_en, fb_addr, fb_data         frame-buffer read port (data one cycle after fb_en)
//   de_out, hsync_out, vsync_out    timing delayed 3 cycles
//   r, g, b                         panel colour, zero outside active pixels
module midas_pixel_fetch #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int DST_W  = 800,
  parameter int DST_H  = 600,
  parameter int ADDR_W = 17
) (
  input  logic              clk_pix,
  input  logic              rstn,
  input  logic              frame_start,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              fb_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [11:0]       fb_data,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [4:0]        r,
  output logic [5:0]        g,
  output logic [4:0]        b
);
  localparam int XW  = $clog2(SRC_W);
  localparam int YW  = $clog2(SRC_H);
  localparam int AXW = $clog2(DST_W + SRC_W);
  localparam int AYW = $clog2(DST_H + SRC_H);

  logic [1:0]        rs;
  logic              rst_ok;
  logic [AXW-1:0]    acc_x, base_x, sum_x;
  logic [XW-1:0]     src_x, base_sx;
  logic [AYW-1:0]    acc_y, sum_y;
  logic [YW-1:0]     src_y;
  logic [ADDR_W-1:0] row_base, pix_addr;
  logic              de_d, line_end, step_x, step_y, x_sat, y_sat;
  logic [2:0]        de_p, hs_p, vs_p;

  // Asserts immediately, releases two clk_pix edges after rstn rises.
  always_ff @(posedge clk_pix or negedge rstn)
    if (!rstn) rs <= '0;
    else       rs <= {rs[0], 1'b1};
  assign rst_ok = rs[1];

  // A frame_start coinciding with a pixel steps that pixel from a cleared state.
  always_comb begin
    line_end = de_d & ~de_in;
    base_x   = frame_start ? '0 : acc_x;
    base_sx  = frame_start ? '0 : src_x;
    sum_x    = base_x + AXW'(SRC_W);
    step_x   = sum_x >= AXW'(DST_W);
    x_sat    = base_sx == XW'(SRC_W - 1);
    sum_y    = acc_y + AYW'(SRC_H);
    step_y   = sum_y >= AYW'(DST_H);
    y_sat    = src_y == YW'(SRC_H - 1);
    pix_addr = frame_start ? '0 : row_base + ADDR_W'(src_x);
  end

  always_ff @(posedge clk_pix or negedge rst_ok)
    if (!rst_ok) begin
      de_d     <= 1'b0;
      fb_addr  <= '0;
      acc_x    <= '0;
      src_x    <= '0;
      acc_y    <= '0;
      src_y    <= '0;
      row_base <= '0;
    end else begin
      de_d <= de_in;
      if (de_in) fb_addr <= pix_addr;
      if (de_in) begin
        acc_x <= step_x ? sum_x - AXW'(DST_W) : sum_x;
        src_x <= (step_x && !x_sat) ? base_sx + 1'b1 : base_sx;
      end else if (frame_start || line_end) begin
        acc_x <= '0;
        src_x <= '0;
      end
      if (frame_start) begin
        acc_y    <= '0;
        src_y    <= '0;
        row_base <= '0;
      end else if (line_end) begin
        acc_y <= step_y ? sum_y - AYW'(DST_H) : sum_y;
        if (step_y && !y_sat) begin
          src_y    <= src_y + 1'b1;
          row_base <= row_base + ADDR_W'(SRC_W);
        end
      end
    end

  // Stage 0 of the timing delay doubles as the read enable.
  always_ff @(posedge clk_pix or negedge rst_ok)
    if (!rst_ok) begin
      de_p <= '0;
      hs_p <= '0;
      vs_p <= '0;
      r    <= '0;
      g    <= '0;
      b    <= '0;
    end else begin
      de_p <= {de_p[1:0], de_in};
      hs_p <= {hs_p[1:0], hsync_in};
      vs_p <= {vs_p[1:0], vsync_in};
      r    <= de_p[1] ? {fb_data[11:8], fb_data[11]}  : '0;
      g    <= de_p[1] ? {fb_data[7:4], fb_data[7:6]}  : '0;
      b    <= de_p[1] ? {fb_data[3:0], fb_data[3]}    : '0;
    end

  assign fb_en     = de_p[0];
  assign de_out    = de_p[2];
  assign hsync_out = hs_p[2];
  assign vsync_out = vs_p[2];
endmodule

// File: tb/tb_midas_pixel_fetch.sv
// tb_midas_pixel_fetch: directed stimulus with an address/pixel scoreboard for midas_pixel_fetch.
module tb_midas_pixel_fetch;
  logic        clk_pix = 1'b0, rstn = 1'b1;
  logic        frame_start = 1'b0, de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic        fb_en, de_out, hsync_out, vsync_out;
  logic [16:0] fb_addr;
  logic [11:0] fb_data = '0;
  logic [4:0]  r, b;
  logic [5:0]  g;

  int total = 0, bad = 0;
  int q_addr[$], q_pix[$];
  int mx = 0, my = 0, n_fetch = 0, last_addr = -1, f0 = 0;
  logic prev_de = 1'b0, ovr = 1'b0;
  logic [2:0] de_h, hs_h, vs_h;

  always #5 clk_pix = ~clk_pix;

  midas_pixel_fetch dut (
    .clk_pix(clk_pix), .rstn(rstn), .frame_start(frame_start), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .fb_en(fb_en), .fb_addr(fb_addr),
    .fb_data(fb_data), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .r(r), .g(g), .b(b)
  );

  function automatic logic [11:0] data_of(input int a);
    return ovr ? 12'hF0A : (12'(a) ^ 12'h5A3);
  endfunction

  function automatic int expand(input logic [11:0] d);
    return int'({d[11:8], d[11], d[7:4], d[7:6], d[3:0], d[3]});
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(posedge clk_pix)
    if (fb_en) fb_data <= data_of(int'(fb_addr));

  always @(posedge clk_pix or negedge rstn)
    if (!rstn) begin
      de_h <= '0;
      hs_h <= '0;
      vs_h <= '0;
    end else begin
      de_h <= {de_h[1:0], de_in};
      hs_h <= {hs_h[1:0], hsync_in};
      vs_h <= {vs_h[1:0], vsync_in};
    end

  always @(negedge clk_pix)
    if (rstn) begin
      if (fb_en) begin
        if (q_addr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fb_en_unexpected actual=%0d expected=none", fb_addr);
        end else begin
          chk("fb_addr", int'(fb_addr), q_addr.pop_front());
          last_addr = int'(fb_addr);
          n_fetch++;
        end
      end
      if (de_out) begin
        if (q_pix.size() == 0) begin
          total++;
          bad++;
          $display("FAIL de_out_unexpected actual=%0d expected=none", {r, g, b});
        end else chk("rgb", int'({r, g, b}), q_pix.pop_front());
      end else chk("rgb_blank", int'({r, g, b}), 0);
      chk("de_dly", int'(de_out), int'(de_h[2]));
      chk("hs_dly", int'(hsync_out), int'(hs_h[2]));
      chk("vs_dly", int'(vsync_out), int'(vs_h[2]));
    end

  task automatic cyc(input logic de, input logic fs, input logic hs = 1'b0, input logic vs = 1'b0);
    @(posedge clk_pix);
    #1;
    de_in = de;
    frame_start = fs;
    hsync_in = hs;
    vsync_in = vs;
    if (fs) begin
      mx = 0;
      my = 0;
    end else if (prev_de && !de) begin
      mx = 0;
      my++;
    end
    if (de) begin
      int xs, ys, a;
      ys = my * 240 / 600;
      if (ys > 239) ys = 239;
      xs = mx * 320 / 800;
      if (xs > 319) xs = 319;
      a = ys * 320 + xs;
      q_addr.push_back(a);
      q_pix.push_back(expand(data_of(a)));
      mx++;
    end
    prev_de = de;
  endtask

  task automatic line(input int n, input logic fs = 1'b0);
    for (int i = 0; i < n; i++) cyc(1'b1, fs && i == 0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    repeat (5) cyc(1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_fb_en"}, int'(fb_en), 0);
    chk({nm, "_fb_addr"}, int'(fb_addr), 0);
    chk({nm, "_de_out"}, int'(de_out), 0);
    chk({nm, "_hsync"}, int'(hsync_out), 0);
    chk({nm, "_vsync"}, int'(vsync_out), 0);
    chk({nm, "_rgb"}, int'({r, g, b}), 0);
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1 chk_zero("reset");
    @(posedge clk_pix);
    #1 rstn = 1'b1;
    repeat (6) cyc(1'b0, 1'b0);
    chk("idle_no_fetch", int'(fb_en), 0);
    chk("idle_fetches", n_fetch, 0);

    // Addressing starts at 0 without any frame_start.
    line(6);
    drain();
    chk("nofs_last", last_addr, 2);

    // Single line mapping.
    f0 = n_fetch;
    line(800, 1'b1);
    drain();
    chk("line_last", last_addr, 319);
    chk("line_fetches", n_fetch - f0, 800);

    // Frame: full lines where the row mapping is interesting, 1-pixel lines elsewhere.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    f0 = n_fetch;
    for (int l = 0; l < 600; l++) line((l < 6 || l == 299 || l == 599) ? 800 : 1);
    drain();
    chk("frame_last", last_addr, 76799);
    chk("frame_fetches", n_fetch - f0, 6992);

    // Latency and colour expansion of 12'hF0A.
    ovr = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("lat_fb_en", int'(fb_en), 1);
    chk("lat_de_early", int'(de_out), 0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("lat_de_out", int'(de_out), 1);
    chk("lat_r", int'(r), 'h1F);
    chk("lat_g", int'(g), 'h00);
    chk("lat_b", int'(b), 'h15);
    chk("lat_hsync", int'(hsync_out), 1);
    chk("lat_vsync", int'(vsync_out), 1);
    cyc(1'b0, 1'b0);
    chk("lat_de_after", int'(de_out), 0);
    chk("lat_rgb_after", int'({r, g, b}), 0);
    ovr = 1'b0;
    drain();

    // Overlong line saturates, next line restarts the row.
    cyc(1'b0, 1'b1);
    line(850);
    drain();
    chk("long_last", last_addr, 319);
    line(10);
    drain();
    chk("long_next_last", last_addr, 3);

    // frame_start coincident with the first pixel after some rows.
    repeat (4) line(5);
    line(5, 1'b1);
    drain();
    chk("coinc_last", last_addr, 1);

    // frame_start at pixel 400 of line 100.
    cyc(1'b0, 1'b1);
    repeat (100) line(1);
    for (int i = 0; i < 800; i++) cyc(1'b1, i == 400);
    cyc(1'b0, 1'b0);
    drain();
    chk("midline_last", last_addr, 159);

    // Reset at pixel 500 of line 300.
    cyc(1'b0, 1'b1);
    repeat (300) line(1);
    for (int i = 0; i < 500; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    rstn = 1'b0;
    q_addr.delete();
    q_pix.delete();
    de_in = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    mx = 0;
    my = 0;
    prev_de = 1'b0;
    #1 chk_zero("midreset");
    repeat (3) @(posedge clk_pix);
    #1 rstn = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    f0 = n_fetch;
    line(10, 1'b1);
    drain();
    chk("rst_restart_last", last_addr, 3);
    chk("rst_restart_fetches", n_fetch - f0, 10);
    chk("queues_empty", q_addr.size() + q_pix.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
